// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared sizes, word width and loader state encoding for the ANN front end
package ann_pkg;

   localparam int WORD_W      = 16;
   localparam int IMAGE_SIZE  = 16;
   localparam int FIRST_LAYER = 16;
   localparam int CNT_W       = 9;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      LOAD_IMAGE   = 2'd1,
      LOAD_WEIGHTS = 2'd2,
      READY        = 2'd3
   } state_t;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter with runtime rollover value, synchronous clear and last-count flag
module flex_counter #(
   parameter int W = ann_pkg::CNT_W
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clear_i,
   input  logic         count_enable_i,
   input  logic [W-1:0] rollover_val_i,
   output logic [W-1:0] count_o,
   output logic         rollover_flag_o
);

   logic [W-1:0] count_q, count_d;

   // Saturating compare keeps the count inside the window even if the rollover value shrinks.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_enable_i) begin
         if (count_q >= rollover_val_i) count_d = '0;
         else                           count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_o         = count_q;
   assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/coef_loader.sv
// rtl/coef_loader.sv - streams an image and double-buffered weight banks into registers for the ANN
module coef_loader #(
   parameter int IMAGE_SIZE  = ann_pkg::IMAGE_SIZE,
   parameter int FIRST_LAYER = ann_pkg::FIRST_LAYER
) (
   input  logic                                                  clk,
   input  logic                                                  n_rst,
   input  logic                                                  start_load,
   input  logic [ann_pkg::WORD_W-1:0]                            data_in,
   input  logic                                                  data_valid,
   output logic                                                  data_ready,
   input  logic                                                  request_coef,
   input  logic                                                  coef_select,
   output logic [IMAGE_SIZE-1:0][ann_pkg::WORD_W-1:0]            image,
   output logic [FIRST_LAYER-1:0][IMAGE_SIZE-1:0][ann_pkg::WORD_W-1:0] weights,
   output logic                                                  image_weights_loaded,
   output logic                                                  coef_loaded
);

   import ann_pkg::*;

   localparam int WEIGHT_WORDS = FIRST_LAYER * IMAGE_SIZE;
   localparam int IMG_AW       = $clog2(IMAGE_SIZE);
   localparam int WGT_AW       = $clog2(WEIGHT_WORDS);
   localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMAGE_SIZE - 1);
   localparam logic [CNT_W-1:0] WGT_LAST = CNT_W'(WEIGHT_WORDS - 1);

   state_t state_q, state_d;
   logic   pending_q, pending_d;
   logic   tgt_bank_q, tgt_bank_d;
   logic   reload_q, reload_d;
   logic   loaded_q, loaded_d;
   logic   coef_loaded_q, coef_loaded_d;

   logic [IMAGE_SIZE-1:0][WORD_W-1:0]        image_q;
   logic [1:0][WEIGHT_WORDS-1:0][WORD_W-1:0] bank_q;

   logic [CNT_W-1:0] cnt, cnt_roll;
   logic             cnt_last, cnt_clear, cnt_en, xfer;

   assign xfer = data_valid && data_ready;

   flex_counter #(.W(CNT_W)) u_word_cnt (
      .clk            (clk),
      .n_rst          (n_rst),
      .clear_i        (cnt_clear),
      .count_enable_i (cnt_en),
      .rollover_val_i (cnt_roll),
      .count_o        (cnt),
      .rollover_flag_o(cnt_last)
   );

   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      tgt_bank_d    = tgt_bank_q;
      reload_d      = reload_q;
      loaded_d      = loaded_q;
      coef_loaded_d = 1'b0;
      cnt_clear     = 1'b0;
      cnt_en        = 1'b0;
      cnt_roll      = WGT_LAST;
      data_ready    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_load) begin
               state_d   = LOAD_IMAGE;
               loaded_d  = 1'b0;
               pending_d = 1'b0;
               cnt_clear = 1'b1;
            end
         end
         LOAD_IMAGE: begin
            data_ready = 1'b1;
            cnt_roll   = IMG_LAST;
            if (request_coef) pending_d = 1'b1;
            if (xfer) begin
               cnt_en = 1'b1;
               if (cnt_last) begin
                  state_d    = LOAD_WEIGHTS;
                  tgt_bank_d = 1'b0;
                  reload_d   = 1'b0;
               end
            end
         end
         LOAD_WEIGHTS: begin
            data_ready = 1'b1;
            if (request_coef) pending_d = 1'b1;
            if (xfer) begin
               cnt_en = 1'b1;
               if (cnt_last) begin
                  state_d = READY;
                  if (reload_q) coef_loaded_d = 1'b1;
                  else          loaded_d      = 1'b1;
               end
            end
         end
         READY: begin
            // A fresh load wins over any reload request and drops it.
            if (start_load) begin
               state_d   = LOAD_IMAGE;
               loaded_d  = 1'b0;
               pending_d = 1'b0;
               cnt_clear = 1'b1;
            end else if (request_coef || pending_q) begin
               state_d    = LOAD_WEIGHTS;
               tgt_bank_d = ~coef_select;
               reload_d   = 1'b1;
               pending_d  = 1'b0;
               cnt_clear  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         pending_q     <= 1'b0;
         tgt_bank_q    <= 1'b0;
         reload_q      <= 1'b0;
         loaded_q      <= 1'b0;
         coef_loaded_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         tgt_bank_q    <= tgt_bank_d;
         reload_q      <= reload_d;
         loaded_q      <= loaded_d;
         coef_loaded_q <= coef_loaded_d;
      end
   end

   // Weight storage is flat row-major, so word k lands at row k/IMAGE_SIZE, column k%IMAGE_SIZE.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         image_q <= '0;
         bank_q  <= '0;
      end else if (xfer) begin
         if (state_q == LOAD_IMAGE) image_q[cnt[IMG_AW-1:0]]             <= data_in;
         else                       bank_q[tgt_bank_q][cnt[WGT_AW-1:0]] <= data_in;
      end
   end

   assign image                = image_q;
   assign weights              = bank_q[coef_select];
   assign image_weights_loaded = loaded_q;
   assign coef_loaded          = coef_loaded_q;

endmodule

// File: tb/tb_coef_loader.sv
// tb/tb_coef_loader.sv - directed bench for coef_loader with hand-computed expectations
module tb_coef_loader;

   logic        clk = 1'b0;
   logic        n_rst, start_load, data_valid, request_coef, coef_select;
   logic [15:0] data_in;
   logic        data_ready, image_weights_loaded, coef_loaded;
   logic [15:0][15:0]        image;
   logic [15:0][15:0][15:0]  weights;

   int total = 0;
   int bad   = 0;

   coef_loader dut (
      .clk                 (clk),
      .n_rst               (n_rst),
      .start_load          (start_load),
      .data_in             (data_in),
      .data_valid          (data_valid),
      .data_ready          (data_ready),
      .request_coef        (request_coef),
      .coef_select         (coef_select),
      .image               (image),
      .weights             (weights),
      .image_weights_loaded(image_weights_loaded),
      .coef_loaded         (coef_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] w, input bit gap);
      int n = 0;
      if (gap) begin
         data_valid = 1'b0;
         @(posedge clk); #1;
      end
      data_in    = w;
      data_valid = 1'b1;
      @(negedge clk);
      while (!data_ready) begin
         n++;
         if (n > 20) begin
            check("rdy_wait", data_ready, 1);
            data_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
   endtask

   task automatic stream(input int first, input int cnt, input logic [15:0] base, input bit gap);
      for (int k = first; k < first + cnt; k++) send(16'(base + 16'(k)), gap);
   endtask

   task automatic pulse(input bit s, input bit r);
      start_load   = s;
      request_coef = r;
      @(posedge clk); #1;
      start_load   = 1'b0;
      request_coef = 1'b0;
   endtask

   initial begin
      n_rst = 1'b0; start_load = 1'b0; data_valid = 1'b0; request_coef = 1'b0;
      coef_select = 1'b0; data_in = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", data_ready, 0);
      check("rst_iwl", image_weights_loaded, 0);
      check("rst_cl", coef_loaded, 0);
      check("rst_img0", image[0], 0);
      check("rst_w00", weights[0][0], 0);
      n_rst = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", data_ready, 0);

      // reset in the middle of a weight load
      pulse(1, 0);
      check("li_ready", data_ready, 1);
      stream(0, 16, 16'h0001, 0);
      stream(0, 100, 16'h1000, 0);
      check("pre_rst_img3", image[3], 16'h0004);
      check("pre_rst_w63", weights[6][3], 16'h1063);
      n_rst = 1'b0;
      #1;
      check("mid_rst_ready", data_ready, 0);
      check("mid_rst_iwl", image_weights_loaded, 0);
      check("mid_rst_img3", image[3], 0);
      check("mid_rst_w63", weights[6][3], 0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_idle", data_ready, 0);

      // full load, valid held high
      pulse(1, 0);
      stream(0, 16, 16'h0001, 0);
      stream(0, 255, 16'h1000, 0);
      check("iwl_before_last", image_weights_loaded, 0);
      send(16'h10FF, 0);
      check("iwl_after_last", image_weights_loaded, 1);
      check("ready_idle_dr", data_ready, 0);
      check("img15", image[15], 16'h0010);
      check("img0", image[0], 16'h0001);
      check("w1515", weights[15][15], 16'h10FF);
      check("w00", weights[0][0], 16'h1000);
      check("w35", weights[3][5], 16'h1035);

      n_rst = 1'b0;
      @(posedge clk); #1;
      n_rst = 1'b1;
      check("rst2_w00", weights[0][0], 0);

      // same load with valid toggling
      pulse(1, 0);
      stream(0, 16, 16'h0001, 1);
      stream(0, 256, 16'h1000, 1);
      check("tog_iwl", image_weights_loaded, 1);
      check("tog_img15", image[15], 16'h0010);
      check("tog_img7", image[7], 16'h0008);
      check("tog_w1515", weights[15][15], 16'h10FF);
      check("tog_w79", weights[7][9], 16'h1079);
      check("tog_w00", weights[0][0], 16'h1000);

      // reload into the inactive bank
      coef_select = 1'b0;
      pulse(0, 1);
      check("rl_ready", data_ready, 1);
      stream(0, 255, 16'h2000, 0);
      check("rl_cl_early", coef_loaded, 0);
      check("rl_w00_held", weights[0][0], 16'h1000);
      send(16'h20FF, 0);
      check("rl_cl_pulse", coef_loaded, 1);
      check("rl_iwl_kept", image_weights_loaded, 1);
      @(posedge clk); #1;
      check("rl_cl_drop", coef_loaded, 0);
      check("rl_ready_dr", data_ready, 0);
      coef_select = 1'b1;
      #1;
      check("rl_w00_b1", weights[0][0], 16'h2000);
      check("rl_w1515_b1", weights[15][15], 16'h20FF);

      // request during image load is serviced after the initial load
      pulse(1, 0);
      stream(0, 4, 16'h0001, 0);
      pulse(0, 1);
      stream(4, 12, 16'h0001, 0);
      stream(0, 256, 16'h3000, 0);
      check("pend_iwl", image_weights_loaded, 1);
      check("pend_w00_b1", weights[0][0], 16'h2000);
      check("pend_ready_dr", data_ready, 0);
      @(posedge clk); #1;
      check("pend_reload_dr", data_ready, 1);
      stream(0, 256, 16'h4000, 0);
      check("pend_cl", coef_loaded, 1);
      coef_select = 1'b0;
      #1;
      check("pend_w00_b0", weights[0][0], 16'h4000);
      check("pend_w1515_b0", weights[15][15], 16'h40FF);

      // start_load beats request_coef
      @(posedge clk); #1;
      pulse(1, 1);
      check("prio_dr", data_ready, 1);
      check("prio_iwl", image_weights_loaded, 0);
      stream(0, 16, 16'h0001, 0);
      stream(0, 256, 16'h5000, 0);
      check("prio_iwl_done", image_weights_loaded, 1);
      check("prio_w00", weights[0][0], 16'h5000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("prio_no_reload", data_ready, 0);
      end
      check("prio_cl", coef_loaded, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
